// File: rtl/ram_rw_seq_pkg.sv
// Shared types, default geometry and the expected-data pattern for the RAM
// write/read sequencer and its read checker.
package ram_test_pkg;

   localparam int DEPTH_DEF  = 64;
   localparam int AW_DEF     = 6;
   localparam int DW_DEF     = 8;
   localparam int RD_LAT_MAX = 3;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      GAP,
      READ,
      DRAIN,
      DONE
   } state_t;

   // Callers truncate the 32-bit sum to DW bits, which gives the mod 2**DW wrap.
   function automatic logic [31:0] exp_data(input logic [31:0] addr, input logic [31:0] seed);
      return addr + seed;
   endfunction

endpackage

// File: rtl/ram_rw_seq_if.sv
// Write/read port bundle between the sequencer (master) and the dual-port RAM (slave).
interface ram_rw_seq_if
   import ram_test_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
);
   logic          ram_wr_en;
   logic [AW-1:0] ram_wr_addr;
   logic [DW-1:0] ram_wr_data;
   logic          ram_rd_en;
   logic [AW-1:0] ram_rd_addr;
   logic [DW-1:0] ram_rd_data;

   modport master (
      output ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr,
      input  ram_rd_data
   );

   modport slave (
      input  ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_en, ram_rd_addr,
      output ram_rd_data
   );
endinterface

// File: rtl/ram_rw_seq_rd_checker.sv
// Delays each read request by the RAM latency and compares the returned word
// with the expected pattern; mismatch_o is a combinational per-cycle strobe.
module ram_rd_checker
   import ram_test_pkg::*;
#(
   parameter int AW     = AW_DEF,
   parameter int DW     = DW_DEF,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rd_en_i,
   input  logic [AW-1:0] rd_addr_i,
   input  logic [DW-1:0] rd_data_i,
   input  logic [DW-1:0] seed_i,
   output logic          mismatch_o
);

   logic [RD_LAT-1:0]         vld_q;
   logic [RD_LAT-1:0][AW-1:0] addr_q;
   logic [DW-1:0]             exp_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         addr_q <= '0;
      end else begin
         vld_q[0]  <= rd_en_i;
         addr_q[0] <= rd_addr_i;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i]  <= vld_q[i-1];
            addr_q[i] <= addr_q[i-1];
         end
      end
   end

   // The last stage lines up with the cycle in which the RAM presents its data.
   assign exp_word   = DW'(exp_data(32'(addr_q[RD_LAT-1]), 32'(seed_i)));
   assign mismatch_o = vld_q[RD_LAT-1] && (rd_data_i != exp_word);

endmodule

// File: rtl/ram_rw_seq.sv
// RAM test sequencer: fills every address with addr+seed, sweeps the read port
// over the same range, and reports done, a sticky error flag and an error count.
module ram_rw_seq
   import ram_test_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int AW     = AW_DEF,
   parameter int DW     = DW_DEF,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] seed,
   ram_rw_seq_if.master  ram,
   output logic          busy,
   output logic          done,
   output logic          err_flag,
   output logic [AW:0]   err_cnt
);

   localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
   localparam logic [1:0]    DRAIN_LAST = 2'(RD_LAT - 1);
   localparam logic [AW:0]   CNT_MAX    = '1;

   state_t        state_q, state_d;
   logic          wr_en_q, wr_en_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [DW-1:0] wr_data_q, wr_data_d;
   logic          rd_en_q, rd_en_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic          done_q, done_d;
   logic [DW-1:0] seed_q, seed_d;
   logic [1:0]    drain_q, drain_d;
   logic          err_flag_q, err_flag_d;
   logic [AW:0]   err_cnt_q, err_cnt_d;
   logic          mismatch;

   ram_rd_checker #(
      .AW     (AW),
      .DW     (DW),
      .RD_LAT (RD_LAT)
   ) u_checker (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_en_i    (rd_en_q),
      .rd_addr_i  (rd_addr_q),
      .rd_data_i  (ram.ram_rd_data),
      .seed_i     (seed_q),
      .mismatch_o (mismatch)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         done_q     <= 1'b0;
         seed_q     <= '0;
         drain_q    <= '0;
         err_flag_q <= 1'b0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         done_q     <= done_d;
         seed_q     <= seed_d;
         drain_q    <= drain_d;
         err_flag_q <= err_flag_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      rd_en_d    = 1'b0;
      rd_addr_d  = rd_addr_q;
      done_d     = 1'b0;
      seed_d     = seed_q;
      drain_d    = drain_q;
      err_flag_d = err_flag_q;
      err_cnt_d  = err_cnt_q;

      if (mismatch) begin
         err_flag_d = 1'b1;
         if (err_cnt_q != CNT_MAX) begin
            err_cnt_d = err_cnt_q + (AW+1)'(1);
         end
      end

      // Outputs are computed one cycle ahead so enables, addresses and data are all registered.
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = WRITE;
               seed_d     = seed;
               wr_en_d    = 1'b1;
               wr_addr_d  = '0;
               wr_data_d  = DW'(exp_data(32'd0, 32'(seed)));
               err_flag_d = 1'b0;
               err_cnt_d  = '0;
            end
         end
         WRITE: begin
            wr_addr_d = wr_addr_q + AW'(1);
            if (wr_addr_q == LAST_ADDR) begin
               state_d = GAP;
            end else begin
               wr_en_d   = 1'b1;
               wr_data_d = DW'(exp_data(32'(wr_addr_q + AW'(1)), 32'(seed_q)));
            end
         end
         GAP: begin
            state_d   = READ;
            rd_en_d   = 1'b1;
            rd_addr_d = '0;
         end
         READ: begin
            rd_addr_d = rd_addr_q + AW'(1);
            if (rd_addr_q == LAST_ADDR) begin
               state_d = DRAIN;
               drain_d = '0;
            end else begin
               rd_en_d = 1'b1;
            end
         end
         DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               drain_d = drain_q + 2'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign ram.ram_wr_en   = wr_en_q;
   assign ram.ram_wr_addr = wr_addr_q;
   assign ram.ram_wr_data = wr_data_q;
   assign ram.ram_rd_en   = rd_en_q;
   assign ram.ram_rd_addr = rd_addr_q;

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign err_flag = err_flag_q;
   assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_ram_rw_seq.sv
// Directed/randomised bench for ram_rw_seq with a behavioural RAM that can
// corrupt or force read data, and a run-level reference for errors and timing.
module tb_ram_rw_seq;

   localparam int DEPTH  = 64;
   localparam int AW     = 6;
   localparam int DW     = 8;
   localparam int RD_LAT = 1;
   localparam int RUN_LAT = 2 * DEPTH + RD_LAT + 2;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [DW-1:0] seed;
   logic          busy;
   logic          done;
   logic          err_flag;
   logic [AW:0]   err_cnt;

   ram_rw_seq_if #(.AW(AW), .DW(DW)) bus ();

   ram_rw_seq #(
      .DEPTH  (DEPTH),
      .AW     (AW),
      .DW     (DW),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .seed     (seed),
      .ram      (bus),
      .busy     (busy),
      .done     (done),
      .err_flag (err_flag),
      .err_cnt  (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM: write on the edge, read data appears RD_LAT edges later.
   logic [DW-1:0] mem   [DEPTH];
   logic [DW-1:0] cmask [DEPTH];
   logic [DW-1:0] pipe  [RD_LAT];
   bit            force_ff;

   always @(posedge clk) begin
      if (bus.ram_wr_en) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
      pipe[0] <= force_ff ? 8'hFF : (mem[bus.ram_rd_addr] ^ cmask[bus.ram_rd_addr]);
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign bus.ram_rd_data = pipe[RD_LAT-1];

   // Bus monitor: cumulative counts; the main sequence takes differences per run.
   int cur_seed;
   int wr_idx, rd_idx;
   int wr_total, wr_bad, rd_total, rd_bad, done_total, both_bad;

   initial begin
      wr_idx = 0; rd_idx = 0; wr_total = 0; wr_bad = 0;
      rd_total = 0; rd_bad = 0; done_total = 0; both_bad = 0;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         wr_idx = 0;
         rd_idx = 0;
      end else begin
         if (bus.ram_wr_en) begin
            wr_total++;
            if (int'(bus.ram_wr_addr) != wr_idx || bus.ram_wr_data != 8'(wr_idx + cur_seed)) wr_bad++;
            wr_idx = (wr_idx + 1) % DEPTH;
         end
         if (bus.ram_rd_en) begin
            rd_total++;
            if (int'(bus.ram_rd_addr) != rd_idx) rd_bad++;
            rd_idx = (rd_idx + 1) % DEPTH;
         end
         if (bus.ram_wr_en && bus.ram_rd_en) both_bad++;
         if (done) done_total++;
      end
   end

   int n_cmp, n_bad;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Expected mismatch count from what the RAM model returns vs addr+seed.
   function automatic int model_errs(input int sd);
      int n = 0;
      for (int a = 0; a < DEPTH; a++) begin
         logic [7:0] e, got;
         e   = 8'(a + sd);
         got = force_ff ? 8'hFF : (e ^ cmask[a]);
         if (got != e) n++;
      end
      return (n > 127) ? 127 : n;
   endfunction

   task automatic clear_faults();
      force_ff = 1'b0;
      for (int a = 0; a < DEPTH; a++) cmask[a] = '0;
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_wr_en"},   32'(bus.ram_wr_en),   0);
      check({pfx, "_wr_addr"}, 32'(bus.ram_wr_addr), 0);
      check({pfx, "_wr_data"}, 32'(bus.ram_wr_data), 0);
      check({pfx, "_rd_en"},   32'(bus.ram_rd_en),   0);
      check({pfx, "_rd_addr"}, 32'(bus.ram_rd_addr), 0);
      check({pfx, "_busy"},    32'(busy),            0);
      check({pfx, "_done"},    32'(done),            0);
      check({pfx, "_errflag"}, 32'(err_flag),        0);
      check({pfx, "_errcnt"},  32'(err_cnt),         0);
   endtask

   // One complete run from a start in IDLE; inputs change 1 time unit after the edge.
   task automatic run(input string name, input int sd, input bit hold, input bit pulses);
      int k, busy_lo, w0, r0, d0, wb0, rb0, bb0, exp_err;
      bit found;
      exp_err = model_errs(sd);
      w0 = wr_total; r0 = rd_total; d0 = done_total;
      wb0 = wr_bad; rb0 = rd_bad; bb0 = both_bad;
      cur_seed = sd;
      seed  = 8'(sd);
      start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      k = 1; busy_lo = 0; found = 0;
      check({name, "_clr_flag"}, 32'(err_flag), 0);
      check({name, "_clr_cnt"},  32'(err_cnt),  0);
      while (!found && k < 400) begin
         if (done) begin
            found = 1;
         end else begin
            if (!busy) busy_lo++;
            if (pulses) start = (k == 70 || k == 100);
            @(posedge clk); #1;
            k++;
         end
      end
      start = 1'b0;
      check({name, "_done_seen"}, 32'(found), 1);
      check({name, "_done_lat"},  32'(k), 32'(RUN_LAT));
      check({name, "_busy_run"},  32'(busy_lo), 0);
      check({name, "_busy_done"}, 32'(busy), 1);
      check({name, "_err_cnt"},   32'(err_cnt), 32'(exp_err));
      check({name, "_err_flag"},  32'(err_flag), 32'(exp_err != 0));
      @(posedge clk); #1;
      check({name, "_done_pulse"}, 32'(done), 0);
      check({name, "_idle"},       32'(busy), 0);
      repeat (3) @(posedge clk);
      #1;
      check({name, "_still_idle"}, 32'(busy), 0);
      check({name, "_n_done"},  32'(done_total - d0), 1);
      check({name, "_n_wr"},    32'(wr_total - w0), 32'(DEPTH));
      check({name, "_n_rd"},    32'(rd_total - r0), 32'(DEPTH));
      check({name, "_wr_seq"},  32'(wr_bad - wb0), 0);
      check({name, "_rd_seq"},  32'(rd_bad - rb0), 0);
      check({name, "_overlap"}, 32'(both_bad - bb0), 0);
      check({name, "_hold_cnt"}, 32'(err_cnt), 32'(exp_err));
      $display("run %-10s seed=%02h latency=%0d err_flag=%0d err_cnt=%0d expected_cnt=%0d",
               name, seed, k, err_flag, err_cnt, exp_err);
   endtask

   initial begin
      int k, d0, sd, n;
      n_cmp = 0; n_bad = 0;
      clear_faults();
      cur_seed = 0;
      rst_n = 1'b0; start = 1'b0; seed = '0;
      #3;
      check_reset_outputs("por");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle_busy", 32'(busy), 0);

      run("seed00", 0, 0, 0);
      check("seed00_mem10", 32'(mem[10]), 32'h0A);
      check("seed00_mem63", 32'(mem[63]), 32'h3F);

      run("seedF0", 32'hF0, 0, 0);
      check("seedF0_mem16", 32'(mem[16]), 32'h00);
      check("seedF0_mem63", 32'(mem[63]), 32'h2F);

      run("rand_clean", int'($urandom_range(0, 255)), 0, 0);

      cmask[5] = 8'h01; cmask[40] = 8'h01;
      sd = int'($urandom_range(0, 255));
      check("two_err_model", 32'(model_errs(sd)), 2);
      run("two_err", sd, 0, 0);
      check("two_err_cnt", 32'(err_cnt), 2);
      clear_faults();
      run("after_err", int'($urandom_range(0, 255)), 0, 0);

      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) cmask[$urandom_range(0, DEPTH-1)] = 8'($urandom_range(1, 255));
      run("rand_err", int'($urandom_range(0, 255)), 0, 0);
      clear_faults();

      run("hold_start", int'($urandom_range(0, 255)), 1, 0);
      run("pulses", int'($urandom_range(0, 255)), 0, 1);

      force_ff = 1'b1;
      run("ff_seed0", 0, 0, 0);
      check("ff_seed0_cnt", 32'(err_cnt), 64);
      run("ff_seedC8", 32'hC8, 0, 0);
      check("ff_seedC8_cnt", 32'(err_cnt), 63);
      clear_faults();

      // Abort mid-READ with errors already flagged; reset must clear everything at once.
      cmask[3] = 8'h10;
      cur_seed = 32'h5A; seed = 8'h5A; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      k = 0;
      while (!(bus.ram_rd_en && bus.ram_rd_addr == 6'd20) && k < 300) begin
         @(posedge clk); #1;
         k++;
      end
      check("abort_reach", 32'(k < 300), 1);
      check("abort_pre_flag", 32'(err_flag), 1);
      d0 = done_total;
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("abort");
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("abort_no_done", 32'(done_total - d0), 0);
      check("abort_idle", 32'(busy), 0);
      clear_faults();
      run("post_abort", int'($urandom_range(0, 255)), 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
